// File: rtl/exe_stage_ctrl.sv
// ---------------------------------------------------------------------------
// exe_stage_ctrl
//
// Execute stage of the pipeline. It holds the ID/EX register, runs the ALU
// on the ID/EX contents, keeps the NZCV status register, resolves branches,
// and holds the EX/MEM register. It reads the decode control bundle exactly
// as the control unit emits it: EXE_CMD, WB_EN, MEM_R_EN, MEM_W_EN, B and S.
//
// Optional feature macro: EXE_BRANCH_COUNT_EN
//   defined   : branch_count counts the branches that leave EX (it wraps).
//   undefined : branch_count is tied to 0 and no counter is built.
//
// Ports
//   clk            in   clock; all state changes on the rising edge
//   rst            in   synchronous active-high reset
//   mem_stall      in   hold ID/EX, EX/MEM and the status register
//   id_bubble      in   load a NOP into ID/EX instead of the id_* inputs
//   id_wb_en       in   decode: register write-back enable
//   id_mem_r_en    in   decode: memory read enable
//   id_mem_w_en    in   decode: memory write enable
//   id_b           in   decode: branch
//   id_s           in   decode: update status flags
//   id_exe_cmd     in   decode: 4-bit ALU command
//   id_val_rn      in   first operand (also the store data)
//   id_val2        in   second operand
//   id_dest        in   destination register index
//   id_pc          in   PC+4 of the instruction
//   id_imm24       in   signed branch offset, in words
//   status         out  {N,Z,C,V}
//   branch_taken   out  B bit of the ID/EX register (combinational)
//   branch_addr    out  ID/EX pc + (sext(imm24) << 2), mod 2^DW
//   mem_wb_en      out  EX/MEM write-back enable
//   mem_r_en       out  EX/MEM memory read enable
//   mem_w_en       out  EX/MEM memory write enable
//   mem_alu_res    out  EX/MEM ALU result
//   mem_st_val     out  EX/MEM val_rn, used as the store data
//   mem_dest       out  EX/MEM destination register index
//   branch_count   out  branch counter (0 when the feature is off)
//
// DW is the datapath width. The ALU and its flags assume DW = 32. RW is the
// width of a register index.
// ---------------------------------------------------------------------------
module exe_stage_ctrl #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_stall,
  input  logic          id_bubble,
  input  logic          id_wb_en,
  input  logic          id_mem_r_en,
  input  logic          id_mem_w_en,
  input  logic          id_b,
  input  logic          id_s,
  input  logic [3:0]    id_exe_cmd,
  input  logic [DW-1:0] id_val_rn,
  input  logic [DW-1:0] id_val2,
  input  logic [RW-1:0] id_dest,
  input  logic [DW-1:0] id_pc,
  input  logic [23:0]   id_imm24,
  output logic [3:0]    status,
  output logic          branch_taken,
  output logic [DW-1:0] branch_addr,
  output logic          mem_wb_en,
  output logic          mem_r_en,
  output logic          mem_w_en,
  output logic [DW-1:0] mem_alu_res,
  output logic [DW-1:0] mem_st_val,
  output logic [RW-1:0] mem_dest,
  output logic [31:0]   branch_count
);

  // ALU command encoding used by the control unit.
  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  // Contents of the ID/EX register. The all-zero value is a NOP.
  typedef struct packed {
    logic          wb_en;
    logic          mem_r_en;
    logic          mem_w_en;
    logic          b;
    logic          s;
    logic [3:0]    exe_cmd;
    logic [DW-1:0] val_rn;
    logic [DW-1:0] val2;
    logic [RW-1:0] dest;
    logic [DW-1:0] pc;
    logic [23:0]   imm24;
  } idex_t;

  // Contents of the EX/MEM register.
  typedef struct packed {
    logic          wb_en;
    logic          mem_r_en;
    logic          mem_w_en;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] st_val;
    logic [RW-1:0] dest;
  } exmem_t;

  localparam int MSB = DW - 1;

  idex_t         idex_q, idex_d;
  exmem_t        exmem_q, exmem_d;
  logic [3:0]    status_q, status_d;

  // ALU signals
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic [DW:0]   alu_sum;
  logic          carry_in;
  logic          flag_n, flag_z, flag_c, flag_v;

  // -------------------------------------------------------------------------
  // Branch resolution. The target is computed from the ID/EX copy, so it
  // stays stable for as long as a stall holds the branch in EX.
  // -------------------------------------------------------------------------
  assign branch_taken = idex_q.b;
  assign branch_addr  = idex_q.pc + {{(DW-26){idex_q.imm24[23]}}, idex_q.imm24, 2'b00};

  // -------------------------------------------------------------------------
  // ID/EX register
  // A taken branch loads a NOP into ID/EX on the edge where the branch
  // leaves EX. This drops the instruction fetched behind it, so no external
  // flush is needed.
  // -------------------------------------------------------------------------
  always_comb begin
    idex_d = idex_q;
    if (!mem_stall) begin
      if (branch_taken || id_bubble) begin
        idex_d = '0;
      end else begin
        idex_d.wb_en    = id_wb_en;
        idex_d.mem_r_en = id_mem_r_en;
        idex_d.mem_w_en = id_mem_w_en;
        idex_d.b        = id_b;
        idex_d.s        = id_s;
        idex_d.exe_cmd  = id_exe_cmd;
        idex_d.val_rn   = id_val_rn;
        idex_d.val2     = id_val2;
        idex_d.dest     = id_dest;
        idex_d.pc       = id_pc;
        idex_d.imm24    = id_imm24;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  // -------------------------------------------------------------------------
  // ALU
  // Subtraction is done as a + ~b + carry_in. The carry out of the top bit
  // is then directly NOT borrow. SUB uses carry_in = 1. SBC uses the stored
  // C, which gives a - b - (~C).
  // -------------------------------------------------------------------------
  assign alu_a = idex_q.val_rn;
  assign alu_b = idex_q.val2;

  always_comb begin
    alu_res  = '0;
    alu_sum  = '0;
    carry_in = 1'b0;
    flag_c   = status_q[1];
    flag_v   = status_q[0];
    case (exe_cmd_e'(idex_q.exe_cmd))
      CMD_MOV: alu_res = alu_b;
      CMD_MVN: alu_res = ~alu_b;
      CMD_AND: alu_res = alu_a & alu_b;
      CMD_ORR: alu_res = alu_a | alu_b;
      CMD_EOR: alu_res = alu_a ^ alu_b;
      CMD_ADD, CMD_ADC: begin
        carry_in = (idex_q.exe_cmd == CMD_ADC) ? status_q[1] : 1'b0;
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {{DW{1'b0}}, carry_in};
        alu_res  = alu_sum[MSB:0];
        flag_c   = alu_sum[DW];
        // Overflow: the operands have the same sign and the result sign differs.
        flag_v   = (alu_a[MSB] == alu_b[MSB]) && (alu_res[MSB] != alu_a[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        carry_in = (idex_q.exe_cmd == CMD_SBC) ? status_q[1] : 1'b1;
        alu_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + {{DW{1'b0}}, carry_in};
        alu_res  = alu_sum[MSB:0];
        flag_c   = alu_sum[DW];
        // Overflow: the operands have different signs and the result sign
        // differs from a.
        flag_v   = (alu_a[MSB] != alu_b[MSB]) && (alu_res[MSB] != alu_a[MSB]);
      end
      default: alu_res = '0;
    endcase
    flag_n = alu_res[MSB];
    flag_z = (alu_res == '0);
  end

  // -------------------------------------------------------------------------
  // Status register
  // A branch never writes flags, even when S is set in the bundle. The new
  // flags land on the edge that ends the EX cycle. A back-to-back ADC or SBC
  // therefore sees the updated C with no forwarding.
  // -------------------------------------------------------------------------
  always_comb begin
    status_d = status_q;
    if (!mem_stall && idex_q.s && !idex_q.b) begin
      status_d = {flag_n, flag_z, flag_c, flag_v};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= 4'b0000;
    end else begin
      status_q <= status_d;
    end
  end

  // -------------------------------------------------------------------------
  // EX/MEM register
  // The enables are masked with B, so a branch never reaches write-back or
  // memory as a real access.
  // -------------------------------------------------------------------------
  always_comb begin
    exmem_d = exmem_q;
    if (!mem_stall) begin
      exmem_d.wb_en    = idex_q.wb_en    & ~idex_q.b;
      exmem_d.mem_r_en = idex_q.mem_r_en & ~idex_q.b;
      exmem_d.mem_w_en = idex_q.mem_w_en & ~idex_q.b;
      exmem_d.alu_res  = alu_res;
      exmem_d.st_val   = idex_q.val_rn;
      exmem_d.dest     = idex_q.dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign status      = status_q;
  assign mem_wb_en   = exmem_q.wb_en;
  assign mem_r_en    = exmem_q.mem_r_en;
  assign mem_w_en    = exmem_q.mem_w_en;
  assign mem_alu_res = exmem_q.alu_res;
  assign mem_st_val  = exmem_q.st_val;
  assign mem_dest    = exmem_q.dest;

  // -------------------------------------------------------------------------
  // Branch counter
  // A branch is counted on the edge where it leaves EX. While a stall holds
  // it in place it is not counted, so every branch is counted exactly once.
  // -------------------------------------------------------------------------
`ifdef EXE_BRANCH_COUNT_EN
  logic [31:0] branch_count_q, branch_count_d;

  always_comb begin
    branch_count_d = branch_count_q;
    if (branch_taken && !mem_stall) begin
      branch_count_d = branch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q <= 32'd0;
    end else begin
      branch_count_q <= branch_count_d;
    end
  end

  assign branch_count = branch_count_q;
`else
  assign branch_count = 32'd0;
`endif

endmodule

// File: tb/tb_exe_stage_ctrl.sv
module tb_exe_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_stall = 1'b0;
  logic        id_bubble = 1'b0;
  logic        id_wb_en = 1'b0, id_mem_r_en = 1'b0, id_mem_w_en = 1'b0, id_b = 1'b0, id_s = 1'b0;
  logic [3:0]  id_exe_cmd = 4'd0;
  logic [31:0] id_val_rn = '0, id_val2 = '0, id_pc = '0;
  logic [3:0]  id_dest = '0;
  logic [23:0] id_imm24 = '0;
  logic [3:0]  status;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        mem_wb_en, mem_r_en, mem_w_en;
  logic [31:0] mem_alu_res, mem_st_val;
  logic [3:0]  mem_dest;
  logic [31:0] branch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage_ctrl #(.DW(32), .RW(4)) dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .id_bubble(id_bubble),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .id_b(id_b), .id_s(id_s), .id_exe_cmd(id_exe_cmd), .id_val_rn(id_val_rn),
    .id_val2(id_val2), .id_dest(id_dest), .id_pc(id_pc), .id_imm24(id_imm24),
    .status(status), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_alu_res(mem_alu_res), .mem_st_val(mem_st_val), .mem_dest(mem_dest),
    .branch_count(branch_count)
  );

  // ---------------- reference model (instruction-level) ----------------
  typedef struct {
    logic        wb, rd, wr, b, s;
    logic [3:0]  cmd;
    logic [31:0] rn, v2, pc;
    logic [3:0]  dest;
    logic [23:0] imm;
  } ins_t;

  ins_t        m_ex;            // instruction currently in EX
  logic        m_wb = 0, m_rd = 0, m_wr = 0;
  logic [31:0] m_res = 0, m_st = 0, m_count = 0;
  logic [3:0]  m_dest = 0, m_status = 0;

  function automatic ins_t nop_ins();
    ins_t n;
    n.wb = 0; n.rd = 0; n.wr = 0; n.b = 0; n.s = 0; n.cmd = 0;
    n.rn = 0; n.v2 = 0; n.pc = 0; n.dest = 0; n.imm = 0;
    return n;
  endfunction

  // Result and flags are computed from exact wide integer arithmetic.
  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] st, output logic [31:0] res, output logic [3:0] fl);
    longint ua, ub, sa, sb, u, s, extra;
    logic c, v;
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    sa = longint'(signed'(a)); sb = longint'(signed'(b));
    c = st[1]; v = st[0]; res = 0; u = 0; s = 0; extra = 0;
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      4'd2, 4'd3: begin
        extra = (cmd == 4'd3 && st[1]) ? 64'sd1 : 64'sd0;
        u = ua + ub + extra; s = sa + sb + extra;
        res = u[31:0];
        c = (u > 64'sd4294967295);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        extra = (cmd == 4'd5 && !st[1]) ? 64'sd1 : 64'sd0;   // borrow in
        u = ua - ub - extra; s = sa - sb - extra;
        res = u[31:0];
        c = (u >= 64'sd0);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: res = 0;
    endcase
    fl = {res[31], (res == 32'd0), c, v};
  endfunction

  function automatic logic [31:0] exp_target(input ins_t i);
    longint off;
    off = longint'(signed'(i.imm)) * 4;
    return i.pc + off[31:0];
  endfunction

  function automatic logic [31:0] exp_count();
`ifdef EXE_BRANCH_COUNT_EN
    return m_count;
`else
    return 32'd0;
`endif
  endfunction

  // One clock: the model consumes the same inputs the DUT samples at this edge.
  task automatic cycle();
    ins_t cur;
    logic [31:0] r;
    logic [3:0] f;
    cur.wb = id_wb_en; cur.rd = id_mem_r_en; cur.wr = id_mem_w_en; cur.b = id_b; cur.s = id_s;
    cur.cmd = id_exe_cmd; cur.rn = id_val_rn; cur.v2 = id_val2; cur.pc = id_pc;
    cur.dest = id_dest; cur.imm = id_imm24;
    @(posedge clk);
    if (rst) begin
      m_ex = nop_ins(); m_wb = 0; m_rd = 0; m_wr = 0; m_res = 0; m_st = 0; m_dest = 0;
      m_status = 0; m_count = 0;
    end else if (!mem_stall) begin
      ref_alu(m_ex.cmd, m_ex.rn, m_ex.v2, m_status, r, f);
      m_wb = m_ex.wb && !m_ex.b; m_rd = m_ex.rd && !m_ex.b; m_wr = m_ex.wr && !m_ex.b;
      m_res = r; m_st = m_ex.rn; m_dest = m_ex.dest;
      if (m_ex.s && !m_ex.b) m_status = f;
      if (m_ex.b) m_count = m_count + 1;
      m_ex = (m_ex.b || id_bubble) ? nop_ins() : cur;
    end
    #1;
  endtask

  task automatic drive(input logic wb, rd, wr, b, s, input logic [3:0] cmd, input logic [31:0] rn, v2,
                       input logic [3:0] dest, input logic [31:0] pc, input logic [23:0] imm);
    id_wb_en = wb; id_mem_r_en = rd; id_mem_w_en = wr; id_b = b; id_s = s; id_exe_cmd = cmd;
    id_val_rn = rn; id_val2 = v2; id_dest = dest; id_pc = pc; id_imm24 = imm;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    idle(); rst = 1; cycle(); cycle(); rst = 0;
    checks++; if (status !== 4'b0000) begin errors++; $display("FAIL reset_status: got %b expected 0000", status); end
    checks++; if ({mem_wb_en, mem_r_en, mem_w_en, branch_taken} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_wb_en, mem_r_en, mem_w_en, branch_taken}); end
    checks++; if (mem_alu_res !== 32'd0 || mem_st_val !== 32'd0 || mem_dest !== 4'd0) begin errors++; $display("FAIL reset_data: got res=%h st=%h dest=%h expected all 0", mem_alu_res, mem_st_val, mem_dest); end
    checks++; if (branch_count !== 32'd0) begin errors++; $display("FAIL reset_bcount: got %h expected 0", branch_count); end
    $display("test_reset: status=%b mem_res=%h", status, mem_alu_res);
  endtask

  task automatic test_add_flags();
    drive(1, 0, 0, 0, 1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 4'd3, 0, 0); cycle();
    idle(); cycle();
    checks++; if (mem_alu_res !== 32'd0) begin errors++; $display("FAIL add_res: got %h expected 00000000", mem_alu_res); end
    checks++; if (status !== 4'b0110) begin errors++; $display("FAIL add_status: got %b expected 0110", status); end
    checks++; if (mem_wb_en !== 1'b1 || mem_dest !== 4'd3) begin errors++; $display("FAIL add_ctrl: got wb=%b dest=%h expected wb=1 dest=3", mem_wb_en, mem_dest); end
    $display("test_add_flags: res=%h status=%b", mem_alu_res, status);
  endtask

  task automatic test_overflow_carry();
    drive(1, 0, 0, 0, 1, 4'b0100, 32'h8000_0000, 32'd1, 4'd1, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 4'b0011, 32'd1, 32'd1, 4'd2, 0, 0); cycle();
    checks++; if (mem_alu_res !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_res: got %h expected 7fffffff", mem_alu_res); end
    checks++; if (status !== 4'b0011) begin errors++; $display("FAIL sub_status: got %b expected 0011", status); end
    idle(); cycle();
    checks++; if (mem_alu_res !== 32'd3) begin errors++; $display("FAIL adc_res: got %h expected 00000003", mem_alu_res); end
    $display("test_overflow_carry: adc res=%h status=%b", mem_alu_res, status);
  endtask

  task automatic test_logical_keep();
    drive(1, 0, 0, 0, 1, 4'b0110, 32'hF0, 32'h0F, 4'd4, 0, 0); cycle();
    idle(); cycle();
    checks++; if (mem_alu_res !== 32'd0) begin errors++; $display("FAIL and_res: got %h expected 00000000", mem_alu_res); end
    checks++; if (status !== 4'b0111) begin errors++; $display("FAIL and_status: got %b expected 0111", status); end
    $display("test_logical_keep: res=%h status=%b", mem_alu_res, status);
  endtask

  task automatic test_branch();
    logic [31:0] cnt0;
    cnt0 = exp_count();
    drive(0, 0, 0, 1, 1, 4'b0010, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd9, 32'h100, 24'hFFFFFE); cycle();
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL br_taken: got %b expected 1", branch_taken); end
    checks++; if (branch_addr !== 32'h0000_00F8) begin errors++; $display("FAIL br_addr: got %h expected 000000f8", branch_addr); end
    drive(1, 1, 1, 0, 1, 4'b0010, 32'd5, 32'd6, 4'd7, 0, 0); cycle();
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL br_flush_taken: got %b expected 0", branch_taken); end
    checks++; if ({mem_wb_en, mem_r_en, mem_w_en} !== 3'b000) begin errors++; $display("FAIL br_no_enables: got %b expected 000", {mem_wb_en, mem_r_en, mem_w_en}); end
    checks++; if (status !== 4'b0111) begin errors++; $display("FAIL br_no_status: got %b expected 0111", status); end
`ifdef EXE_BRANCH_COUNT_EN
    checks++; if (branch_count !== cnt0 + 32'd1) begin errors++; $display("FAIL br_count: got %h expected %h", branch_count, cnt0 + 32'd1); end
`else
    checks++; if (branch_count !== 32'd0) begin errors++; $display("FAIL br_count_off: got %h expected 0", branch_count); end
`endif
    idle(); cycle();
    checks++; if (mem_wb_en !== 1'b0 || mem_dest !== 4'd0 || mem_alu_res !== 32'd0) begin errors++; $display("FAIL br_nop_slot: got wb=%b dest=%h res=%h expected 0/0/0", mem_wb_en, mem_dest, mem_alu_res); end
    checks++; if (status !== 4'b0111) begin errors++; $display("FAIL br_nop_status: got %b expected 0111", status); end
    $display("test_branch: addr=f8 count=%h", branch_count);
  endtask

  task automatic test_stall();
    logic [31:0] s_res, s_cnt;
    logic [3:0]  s_st;
    logic        s_wb;
    drive(0, 0, 0, 1, 0, 4'b0010, 32'd1, 32'd2, 4'd5, 32'h200, 24'h000001); cycle();
    s_res = m_res; s_st = m_status; s_wb = m_wb; s_cnt = exp_count();
    mem_stall = 1;
    drive(1, 0, 1, 0, 1, 4'b0100, 32'd9, 32'd3, 4'd6, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++; if (branch_taken !== 1'b1 || branch_addr !== 32'h204) begin errors++; $display("FAIL stall_branch[%0d]: got taken=%b addr=%h expected 1/00000204", k, branch_taken, branch_addr); end
      checks++; if (mem_alu_res !== s_res || mem_wb_en !== s_wb) begin errors++; $display("FAIL stall_mem[%0d]: got res=%h wb=%b expected %h/%b", k, mem_alu_res, mem_wb_en, s_res, s_wb); end
      checks++; if (status !== s_st || branch_count !== s_cnt) begin errors++; $display("FAIL stall_state[%0d]: got st=%b cnt=%h expected %b/%h", k, status, branch_count, s_st, s_cnt); end
    end
    mem_stall = 0; cycle();
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL stall_release_taken: got %b expected 0", branch_taken); end
    checks++; if (branch_count !== exp_count()) begin errors++; $display("FAIL stall_release_count: got %h expected %h", branch_count, exp_count()); end
    idle(); cycle();
    $display("test_stall: count=%h", branch_count);
  endtask

  task automatic test_reset_midflight();
    drive(1, 1, 0, 0, 1, 4'b0010, 32'h1000, 32'd4, 4'd8, 0, 0); cycle();
    idle(); rst = 1; cycle(); rst = 0;
    checks++; if ({mem_wb_en, mem_r_en, mem_w_en} !== 3'b000 || mem_alu_res !== 32'd0 || mem_dest !== 4'd0) begin errors++; $display("FAIL rstmid_mem: got en=%b res=%h dest=%h expected 0", {mem_wb_en, mem_r_en, mem_w_en}, mem_alu_res, mem_dest); end
    checks++; if (status !== 4'b0000 || branch_count !== 32'd0) begin errors++; $display("FAIL rstmid_state: got st=%b cnt=%h expected 0000/0", status, branch_count); end
    drive(0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 32'h40, 24'h10); cycle();
    idle(); rst = 1; cycle(); rst = 0;
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL rstmid_taken: got %b expected 0", branch_taken); end
    $display("test_reset_midflight: status=%b taken=%b", status, branch_taken);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_back_to_back();
    int bad;
    int fails_before;
    fails_before = errors;
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      mem_stall = ($urandom_range(0, 4) == 0);
      id_bubble = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 5) == 0), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
            pick_val(), pick_val(), 4'($urandom_range(0, 15)), $urandom, 24'($urandom));
      cycle();
      bad = 0;
      checks++; if (status !== m_status) begin bad++; $display("FAIL rnd_status[%0d]: got %b expected %b", n, status, m_status); end
      checks++; if (mem_alu_res !== m_res) begin bad++; $display("FAIL rnd_res[%0d]: got %h expected %h", n, mem_alu_res, m_res); end
      checks++; if ({mem_wb_en, mem_r_en, mem_w_en} !== {m_wb, m_rd, m_wr}) begin bad++; $display("FAIL rnd_en[%0d]: got %b expected %b", n, {mem_wb_en, mem_r_en, mem_w_en}, {m_wb, m_rd, m_wr}); end
      checks++; if (mem_st_val !== m_st || mem_dest !== m_dest) begin bad++; $display("FAIL rnd_st[%0d]: got %h/%h expected %h/%h", n, mem_st_val, mem_dest, m_st, m_dest); end
      checks++; if (branch_taken !== m_ex.b) begin bad++; $display("FAIL rnd_taken[%0d]: got %b expected %b", n, branch_taken, m_ex.b); end
      checks++; if (m_ex.b && branch_addr !== exp_target(m_ex)) begin bad++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, branch_addr, exp_target(m_ex)); end
      checks++; if (branch_count !== exp_count()) begin bad++; $display("FAIL rnd_count[%0d]: got %h expected %h", n, branch_count, exp_count()); end
      errors += bad;
      $display("rnd[%0d]: rst=%b stall=%b res=%h status=%b taken=%b", n, rst, mem_stall, mem_alu_res, status, branch_taken);
    end
    rst = 0; mem_stall = 0; id_bubble = 0; idle(); cycle();
    $display("test_back_to_back: %0d new errors", errors - fails_before);
  endtask

  initial begin
    m_ex = nop_ins();
    test_reset();
    test_add_flags();
    test_overflow_carry();
    test_logical_keep();
    test_branch();
    test_stall();
    test_reset_midflight();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage_ctrl.md
Name: exe_stage_ctrl

Overview:
- Execute-side consumer of the decode control bundle: ID/EX pipeline register, EXE_CMD-decoding ALU, NZCV status register, branch resolution and EX/MEM pipeline register.
- Sits between decode and memory stages.
- Interprets exactly the EXE_CMD / WB_EN / MEM_R_EN / MEM_W_EN / B / S encoding the control unit emits.

Parameters:
- DW, 32, datapath width; the ALU is fixed at 32 bits.
- RW, 4, destination register index width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_stall  in  1  hold both pipeline registers and the status register.
- id_bubble  in  1  load a NOP into ID/EX instead of the id_* inputs.
- id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s  in  1 each  decode control bundle.
- id_exe_cmd  in  4  ALU command.
- id_val_rn  in  DW  first operand.
- id_val2  in  DW  second operand.
- id_dest  in  RW  destination register.
- id_pc  in  DW  PC+4 of the instruction.
- id_imm24  in  24  signed branch offset, in words.
- status  out  4  {N,Z,C,V} register.
- branch_taken  out  1  combinational; B bit in ID/EX is set.
- branch_addr  out  DW  id_pc_reg + (sext(imm24) << 2), mod 2^32.
- mem_wb_en, mem_r_en, mem_w_en  out  1 each  registered EX/MEM controls.
- mem_alu_res  out  DW  registered ALU result.
- mem_st_val  out  DW  registered val_rn, used as store data.
- mem_dest  out  RW  registered destination.
- branch_count  out  32  see Optional Feature.

Behaviour:
- Reset: all outputs and registers are 0, including status = 4'b0000 and branch_count = 0. NOP = all enables 0, exe_cmd 0000.
- ID/EX update priority each edge: rst > mem_stall (hold) > (branch_taken | id_bubble) loads NOP > load id_* inputs.
- branch_taken forcing a NOP flushes the instruction behind the branch in one cycle, with no external flush needed.
- ALU is combinational on ID/EX contents. a = val_rn, b = val2, c = status.C.
  - 0001: b
  - 1001: ~b
  - 0010: a+b
  - 0011: a+b+c
  - 0100: a-b
  - 0101: a-b-(~c)
  - 0110: a&b
  - 0111: a|b
  - 1000: a^b
  - 0000 and 1010-1111: result 0.
- Flags:
  - N = res[31]; Z = (res == 0).
  - ADD/ADC: C = carry out of bit 31 (33-bit sum).
  - SUB/SBC: C = NOT borrow (1 when a >= b + borrow, unsigned).
  - V for add/sub: signed overflow of the operands actually used.
  - Logical/MOV/MVN: C and V retain their previous values.
- Status register loads the new flags at the edge ending an EX cycle when the registered S = 1 and mem_stall = 0.
- A following ADC/SBC therefore sees the updated C with no forwarding.
- EX/MEM register: rst > mem_stall (hold) > load ALU result and controls.
- Latency: id_* to mem_* is 2 edges; id_* to status update is 2 edges.
- During mem_stall, branch_taken and branch_addr stay asserted and stable because ID/EX holds.
- A branch (B = 1) writes no status, never asserts WB or memory enables, and is counted once. Counting happens on the edge where it leaves EX, not while stalled.
- rst mid-operation discards all in-flight instructions. branch_taken drops in the cycle after the reset edge.
- Wrap-around: all arithmetic and branch_addr are mod 2^32. Overflow is reported only via C and V.

Optional Feature:
- Macro: EXE_BRANCH_COUNT_EN.
- When defined:
  - branch_count is a 32-bit counter, incremented when branch_taken = 1 and mem_stall = 0 at a rising edge.
  - It wraps 0xFFFFFFFF -> 0 and is cleared by rst.
- When undefined: branch_count is tied to 0 and no counter logic is generated.

Test Plan:
- ADD flags: cmd 0010, S=1, a=0xFFFFFFFF, b=1 -> mem_alu_res=0 after 2 edges; status=0110 (Z, C).
- Signed overflow then carry chain: SUB S=1 a=0x80000000 b=1 -> res 0x7FFFFFFF, status=0011. Next cycle ADC a=1 b=1 -> res 3.
- Logical keeps C/V: status=0011, then AND S=1 a=0xF0 b=0x0F -> res 0, status=0111.
- Branch: id_b=1, id_pc=0x100, imm24=0xFFFFFE -> branch_taken=1, branch_addr=0x0F8. Next ID/EX entry is NOP even with id_wb_en=1; with EXE_BRANCH_COUNT_EN, branch_count=1.
- Stall hold: mem_stall=1 for 3 cycles during a branch -> branch_taken held 3 cycles, mem_* unchanged, status unchanged, branch_count incremented exactly once.
- Reset mid-flight: LDR (cmd 0010, MEM_R=1, WB=1) in EX, rst=1 -> next cycle all mem_* = 0, status = 0000, branch_count = 0.
